quad_decoder_counter: RTL and testbench
=======================================

// Module: quad_decoder_counter
// PURPOSE
//   Receive side of a quadrature (A/B) encoder interface. Synchronises the
//   asynchronous enc_a/enc_b lines and decodes each legal Gray-code step into
//   up or down. Drives a WIDTH-bit position count with a direction output,
//   matching the up/down counter convention (dir=1 up, dir=0 down).
//   Sits between an external encoder pin pair and position-consuming logic.
// PARAMETERS
//   WIDTH        4   width of position count
//   SYNC_STAGES  2   synchroniser flops per input (legal range 2..4)
// PORTS
//   clk      in   1      system clock, all logic on rising edge
//   reset    in   1      asynchronous, active-low reset
//   enc_a    in   1      encoder phase A, asynchronous to clk
//   enc_b    in   1      encoder phase B, asynchronous to clk
//   clr      in   1      synchronous clear of count, active-high
//   count    out  WIDTH  position count
//   dir      out  1      direction of last legal step (1 = up, 0 = down)
//   step     out  1      one-cycle pulse per legal step decoded
//   err      out  1      one-cycle pulse per illegal (double-bit) transition
// BEHAVIOUR
//   - Reset (reset=0): sync flops=0, prev={0,0}, count=0, dir=1, step=0,
//     err=0, first-sample flag set. All outputs take effect asynchronously.
//   - Sync: each input passes through SYNC_STAGES flops; s={a_sync,b_sync}.
//   - First sample after reset release: prev<=s, flag cleared, no step, no
//     err. Avoids a false err when the encoder rests at a non-00 state.
//   - Then every cycle compares prev->s and sets prev<=s:
//       up   : 00->01, 01->11, 11->10, 10->00 -> step=1, dir<=1, count+1
//       down : 00->10, 10->11, 11->01, 01->00 -> step=1, dir<=0, count-1
//       same : no change; step=0, err=0
//       illegal (00<->11, 01<->10): err=1; count and dir hold
//   - step, err, dir, count are registered; they update on the clock edge
//     after s changes. Pin edge to count change is SYNC_STAGES+1 clocks.
//   - Arithmetic is modulo 2^WIDTH. Up from all-ones gives 0. Down from 0
//     gives all-ones.
//   - clr=1: count<=0 that cycle and overrides any concurrent step. step and
//     dir still report the decoded step. err is unaffected by clr.
//   - reset asserted mid-sequence: immediate return to the reset state. The
//     first-sample rule applies again on release.
//   - step and err are never both 1 in the same cycle.
// CONFIGURATION
//   QDEC_SAT_EN defined: count saturates instead of wrapping.
//     - Up at all-ones holds all-ones. Down at 0 holds 0.
//     - step and dir still update at the limit.
//   QDEC_SAT_EN undefined: modulo wrap as specified above.
// TESTING
//   1 reset=0 for 3 clk, enc=00 -> count=0, dir=1, step=0, err=0.
//   2 Release with enc held 11 -> no err. Then 4 up steps 11->10->00->01->11,
//     each held 4 clk -> count=4, dir=1, 4 step pulses, each 3 clk after edge.
//   3 From count=4, 6 down steps -> count=14 (wrap past 0), dir=0;
//     with QDEC_SAT_EN -> count=0, dir=0, 6 step pulses.
//   4 Force 00->11 in one sample -> err=1 for exactly 1 clk; count and dir hold.
//   5 clr=1 in the same cycle as an up step at count=7 -> count=0, step=1, dir=1.
//   6 reset=0 mid-sequence at count=9 -> count=0, dir=1 immediately (no clk edge);
//     after release, count resumes from 0.

Source files
------------

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B receiver: synchronises the pins, decodes Gray-code steps and tracks position.
// Optional macro QDEC_SAT_EN makes the count saturate at 0 / all-ones instead of wrapping.
module quad_decoder_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic [1:0]             prev_q;
  logic [1:0]             s_c;
  logic                   prime_c;
  logic                   live_c;
  logic                   up_c;
  logic                   down_c;
  logic                   bad_c;
  logic [WIDTH-1:0]       count_nxt_c;

  assign s_c = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // The first sample is held off until the synchroniser has flushed its reset zeros,
  // so an encoder resting at a non-00 state never produces a spurious transition.
  assign prime_c = fill_q[SYNC_STAGES-1] & ~fill_q[SYNC_STAGES];
  assign live_c  = fill_q[SYNC_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      fill_q   <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
      fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Classify the prev->current pair as up, down, illegal or no change.
  always_comb begin
    up_c   = 1'b0;
    down_c = 1'b0;
    bad_c  = 1'b0;
    if (live_c) begin
      case ({prev_q, s_c})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up_c   = 1'b1;
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: down_c = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad_c  = 1'b1;
        default: ;
      endcase
    end
  end

  // Next count: clear wins over any decoded step.
  always_comb begin
    count_nxt_c = count;
    if (clr) begin
      count_nxt_c = '0;
    end else if (up_c) begin
`ifdef QDEC_SAT_EN
      if (count != '1) count_nxt_c = count + WIDTH'(1);
`else
      count_nxt_c = count + WIDTH'(1);
`endif
    end else if (down_c) begin
`ifdef QDEC_SAT_EN
      if (count != '0) count_nxt_c = count - WIDTH'(1);
`else
      count_nxt_c = count - WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 2'b00;
      count  <= '0;
      dir    <= 1'b1;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (prime_c || live_c) prev_q <= s_c;
      count <= count_nxt_c;
      step  <= up_c | down_c;
      err   <= bad_c;
      if (up_c) dir <= 1'b1;
      else if (down_c) dir <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Self-checking bench for quad_decoder_counter: directed scenarios plus random walks
// checked against an encoder-phase model.
module tb_quad_decoder_counter;

  localparam int unsigned WIDTH = 4;
  localparam int CMAX = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             enc_a;
  logic             enc_b;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: encoder phase index into the Gray cycle 00,01,11,10.
  int phase     = 0;
  int exp_count = 0;
  int exp_dir   = 1;
  int exp_steps = 0;
  int exp_errs  = 0;

  int step_seen = 0;
  int err_seen  = 0;
  int both_seen = 0;

  quad_decoder_counter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .clr   (clr),
    .count (count),
    .dir   (dir),
    .step  (step),
    .err   (err)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (step) step_seen++;
    if (err) err_seen++;
    if (step && err) both_seen++;
  end

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0: gray = 2'b00;
      1: gray = 2'b01;
      2: gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_seen();
    step_seen = 0; err_seen = 0; exp_steps = 0; exp_errs = 0;
  endtask

  // Move the encoder: +1 up, -1 down, 2 illegal double-bit jump, 0 no change.
  task automatic model_move(input int d);
    if (d == 2) begin
      phase = (phase + 2) & 3;
      exp_errs++;
    end else if (d == 1) begin
      phase = (phase + 1) & 3;
      exp_steps++;
      exp_dir = 1;
`ifdef QDEC_SAT_EN
      if (exp_count < CMAX) exp_count++;
`else
      exp_count = (exp_count + 1) % (CMAX + 1);
`endif
    end else if (d == -1) begin
      phase = (phase + 3) & 3;
      exp_steps++;
      exp_dir = 0;
`ifdef QDEC_SAT_EN
      if (exp_count > 0) exp_count--;
`else
      exp_count = (exp_count + CMAX) % (CMAX + 1);
`endif
    end
    {enc_a, enc_b} = gray(phase);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_count = 0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0; clr = 1'b0; phase = 0; {enc_a, enc_b} = 2'b00;
    exp_count = 0; exp_dir = 1;
    tick(3);
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %b exp 1", dir); end
    n_tests++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step got %b exp 0", step); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_first_sample();
    phase = 2; {enc_a, enc_b} = gray(phase);
    tick(1);
    clear_seen();
    reset = 1'b1;
    tick(6);
    n_tests++; if (err_seen !== 0) begin n_fail++; $display("FAIL first_sample_err got %0d exp 0", err_seen); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL first_sample_count got %0d exp 0", count); end
  endtask

  task automatic test_up_steps();
    int old;
    clear_seen();
    for (int i = 0; i < 4; i++) begin
      old = exp_count;
      model_move(1);
      for (int k = 1; k <= 4; k++) begin
        tick(1);
        n_tests++;
        if (step !== (k == 3)) begin n_fail++; $display("FAIL up_latency step %0d clk %0d got %b", i, k, step); end
        if (k >= 3) begin
          n_tests++;
          if (count !== WIDTH'(exp_count)) begin n_fail++; $display("FAIL up_count got %0d exp %0d", count, exp_count); end
        end else begin
          n_tests++;
          if (count !== WIDTH'(old)) begin n_fail++; $display("FAIL up_count_early got %0d exp %0d", count, old); end
        end
      end
    end
    n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL up_dir got %b exp 1", dir); end
    n_tests++; if (step_seen !== 4) begin n_fail++; $display("FAIL up_pulses got %0d exp 4", step_seen); end
  endtask

  task automatic test_down_wrap();
    clear_seen();
    for (int i = 0; i < 6; i++) begin
      model_move(-1);
      tick(4);
      n_tests++;
      if (count !== WIDTH'(exp_count)) begin n_fail++; $display("FAIL down_count step %0d got %0d exp %0d", i, count, exp_count); end
    end
    n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL down_dir got %b exp 0", dir); end
    n_tests++; if (step_seen !== 6) begin n_fail++; $display("FAIL down_pulses got %0d exp 6", step_seen); end
  endtask

  task automatic test_illegal();
    int c0;
    logic d0;
    clear_seen();
    c0 = exp_count; d0 = dir;
    model_move(2);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      n_tests++;
      if (err !== (k == 3)) begin n_fail++; $display("FAIL illegal_err clk %0d got %b", k, err); end
    end
    n_tests++; if (count !== WIDTH'(c0)) begin n_fail++; $display("FAIL illegal_count got %0d exp %0d", count, c0); end
    n_tests++; if (dir !== d0) begin n_fail++; $display("FAIL illegal_dir got %b exp %b", dir, d0); end
    n_tests++; if (step_seen !== 0) begin n_fail++; $display("FAIL illegal_step got %0d exp 0", step_seen); end
  endtask

  task automatic test_clr_collision();
    pulse_clr();
    model_move(-1);
    tick(4);
    pulse_clr();
    for (int i = 0; i < 7; i++) begin model_move(1); tick(2); end
    tick(3);
    n_tests++; if (count !== WIDTH'(7)) begin n_fail++; $display("FAIL clr_pre_count got %0d exp 7", count); end
    model_move(1);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_count = 0;
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", count); end
    n_tests++; if (step !== 1'b1) begin n_fail++; $display("FAIL clr_step got %b exp 1", step); end
    n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL clr_dir got %b exp 1", dir); end
    tick(3);
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL clr_hold got %0d exp 0", count); end
  endtask

  task automatic test_random();
    int r;
    for (int round = 0; round < 6; round++) begin
      clear_seen();
      for (int m = 0; m < 30; m++) begin
        r = $urandom_range(0, 9);
        if (r < 4) model_move(1);
        else if (r < 8) model_move(-1);
        else if (r == 8) model_move(2);
        else model_move(0);
        tick($urandom_range(1, 3));
      end
      tick(5);
      n_tests++; if (count !== WIDTH'(exp_count)) begin n_fail++; $display("FAIL rand_count round %0d got %0d exp %0d", round, count, exp_count); end
      n_tests++; if (dir !== exp_dir[0]) begin n_fail++; $display("FAIL rand_dir round %0d got %b exp %0d", round, dir, exp_dir); end
      n_tests++; if (step_seen !== exp_steps) begin n_fail++; $display("FAIL rand_steps round %0d got %0d exp %0d", round, step_seen, exp_steps); end
      n_tests++; if (err_seen !== exp_errs) begin n_fail++; $display("FAIL rand_errs round %0d got %0d exp %0d", round, err_seen, exp_errs); end
    end
  endtask

  task automatic test_reset_mid();
    pulse_clr();
    for (int i = 0; i < 10; i++) begin model_move(1); tick(2); end
    model_move(-1);
    tick(5);
    n_tests++; if (count !== WIDTH'(9)) begin n_fail++; $display("FAIL mid_pre_count got %0d exp 9", count); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL mid_async_count got %0d exp 0", count); end
    n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL mid_async_dir got %b exp 1", dir); end
    exp_count = 0; exp_dir = 1;
    tick(2);
    clear_seen();
    reset = 1'b1;
    tick(6);
    n_tests++; if (err_seen !== 0) begin n_fail++; $display("FAIL mid_release_err got %0d exp 0", err_seen); end
    model_move(1);
    tick(4);
    n_tests++; if (count !== WIDTH'(1)) begin n_fail++; $display("FAIL mid_resume_count got %0d exp 1", count); end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
    test_reset();
    test_first_sample();
    test_up_steps();
    test_down_wrap();
    test_illegal();
    test_clr_collision();
    test_random();
    test_reset_mid();
    n_tests++; if (both_seen !== 0) begin n_fail++; $display("FAIL step_err_exclusive got %0d exp 0", both_seen); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
